// File: rtl/ping_pong_display_scanner.sv
// Time-multiplexes a 0-15 count and a direction flag onto a 4-digit common-anode display.
// Optional LEADING_ZERO_BLANK_EN keeps the tens digit dark when the value is below 10.
module ping_pong_display_scanner #(
  parameter int unsigned SCAN_DIV     = 2048,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] value,
  input  logic       direction,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_start
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYCLES);

  localparam logic [6:0] SegDark = 7'b1111111;
  localparam logic [6:0] SegUp   = 7'b0011101;
  localparam logic [6:0] SegDown = 7'b1100011;

  typedef enum logic [0:0] {StBlank, StDrive} phase_e;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      snap_val_q, snap_val_d;
  logic            snap_dir_q, snap_dir_d;
  phase_e          phase_q, phase_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            frame_start_q, frame_start_d;

  logic       slot_wrap;
  logic       snap_load;
  logic       val_ge10;
  logic [3:0] ones_val;
  logic [6:0] dir_glyph;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b0000001;
      4'd1:    g = 7'b1001111;
      4'd2:    g = 7'b0010010;
      4'd3:    g = 7'b0000110;
      4'd4:    g = 7'b1001100;
      4'd5:    g = 7'b0100100;
      4'd6:    g = 7'b0100000;
      4'd7:    g = 7'b0001111;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0000100;
      default: g = SegDark;
    endcase
    return g;
  endfunction

  // Slot timer, slot index and frame snapshot.
  always_comb begin
    slot_wrap     = (cnt_q == CntMax);
    cnt_d         = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d         = slot_wrap ? idx_q + 2'd1 : idx_q;
    snap_load     = slot_wrap && (idx_q == 2'd3);
    snap_val_d    = snap_load ? value : snap_val_q;
    snap_dir_d    = snap_load ? direction : snap_dir_q;
    frame_start_d = snap_load;
  end

  // Phase FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= StBlank;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase FSM: next state.
  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      StBlank: if (cnt_d == BlankEnd) phase_d = StDrive;
      StDrive: if (slot_wrap)         phase_d = StBlank;
      default: phase_d = StBlank;
    endcase
  end

  // Phase FSM: outputs, registered below for one cycle of latency.
  always_comb begin
    val_ge10  = (snap_val_q >= 4'd10);
    ones_val  = val_ge10 ? snap_val_q - 4'd10 : snap_val_q;
    dir_glyph = snap_dir_q ? SegUp : SegDown;
    an_d      = 4'b1111;
    seg_d     = SegDark;
    if (phase_q == StDrive) begin
      unique case (idx_q)
        2'd0: begin
`ifdef LEADING_ZERO_BLANK_EN
          if (val_ge10) begin
            an_d  = 4'b0111;
            seg_d = digit_glyph(4'd1);
          end
`else
          an_d  = 4'b0111;
          seg_d = val_ge10 ? digit_glyph(4'd1) : digit_glyph(4'd0);
`endif
        end
        2'd1: begin
          an_d  = 4'b1011;
          seg_d = digit_glyph(ones_val);
        end
        2'd2: begin
          an_d  = 4'b1101;
          seg_d = dir_glyph;
        end
        2'd3: begin
          an_d  = 4'b1110;
          seg_d = dir_glyph;
        end
        default: begin
          an_d  = 4'b1111;
          seg_d = SegDark;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= 2'd0;
      snap_val_q    <= 4'd0;
      snap_dir_q    <= 1'b1;
      seg_q         <= SegDark;
      an_q          <= 4'b1111;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      snap_val_q    <= snap_val_d;
      snap_dir_q    <= snap_dir_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ping_pong_display_scanner.sv
// Directed bench for ping_pong_display_scanner with SCAN_DIV=8, BLANK_CYCLES=2.
// Honours LEADING_ZERO_BLANK_EN for the tens-slot expectations.
module tb_ping_pong_display_scanner;

  localparam int unsigned SD = 8;
  localparam int unsigned BC = 2;

  localparam logic [6:0] Dark = 7'b1111111;
  localparam logic [6:0] Up   = 7'b0011101;
  localparam logic [6:0] Down = 7'b1100011;

  logic       clk;
  logic       rst;
  logic [3:0] value;
  logic       direction;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_start;

  int n_checks = 0;
  int n_pass   = 0;

  ping_pong_display_scanner #(
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .direction  (direction),
    .seg        (seg),
    .an         (an),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] digit(input int d);
    case (d)
      0:       return 7'b0000001;
      1:       return 7'b1001111;
      2:       return 7'b0010010;
      3:       return 7'b0000110;
      4:       return 7'b1001100;
      5:       return 7'b0100100;
      6:       return 7'b0100000;
      7:       return 7'b0001111;
      8:       return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e);
    n_checks++;
    assert ({an, seg} === {an_e, seg_e}) n_pass++;
    else $error("FAIL %s: an=%b seg=%b, expected an=%b seg=%b", tag, an, seg, an_e, seg_e);
  endtask

  task automatic chk_fs(input string tag, input logic fs_e);
    n_checks++;
    assert (frame_start === fs_e) n_pass++;
    else $error("FAIL %s frame_start: got %b, expected %b", tag, frame_start, fs_e);
  endtask

  // One full slot: BC dark cycles, then the active digit; frame_start only on the last cycle.
  task automatic slot(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                      input logic fs_last);
    for (int i = 0; i < SD; i++) begin
      tick();
      if (i < BC) chk_disp(tag, 4'b1111, Dark);
      else        chk_disp(tag, an_e, seg_e);
      chk_fs(tag, (i == SD - 1) ? fs_last : 1'b0);
    end
  endtask

  task automatic tens(input string tag, input int v);
    if (v >= 10) slot(tag, 4'b0111, digit(1), 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
    else slot(tag, 4'b1111, Dark, 1'b0);
`else
    else slot(tag, 4'b0111, digit(0), 1'b0);
`endif
  endtask

  task automatic frame(input string tag, input int v, input logic up);
    tens({tag, "_tens"}, v);
    slot({tag, "_ones"}, 4'b1011, digit(v % 10), 1'b0);
    slot({tag, "_dir2"}, 4'b1101, up ? Up : Down, 1'b0);
    slot({tag, "_dir3"}, 4'b1110, up ? Up : Down, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    value     = 4'd7;
    direction = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_disp("reset", 4'b1111, Dark);
      chk_fs("reset", 1'b0);
    end
    rst = 1'b0;

    // Frame 0 always shows the reset snapshot 0/up; 7/down is captured at its end.
    frame("f0", 0, 1'b1);
    value = 4'd12;
    frame("f1", 7, 1'b0);

    // Inputs moving mid-frame must not disturb the frame on screen.
    tens("f2_tens", 12);
    slot("f2_ones", 4'b1011, digit(2), 1'b0);
    value     = 4'd3;
    direction = 1'b1;
    slot("f2_dir2", 4'b1101, Down, 1'b0);
    direction = 1'b0;
    slot("f2_dir3", 4'b1110, Down, 1'b1);

    value     = 4'd9;
    direction = 1'b1;
    frame("f3", 3, 1'b0);
    value = 4'd10;
    frame("f4", 9, 1'b1);
    value     = 4'd15;
    direction = 1'b0;
    frame("f5", 10, 1'b1);
    value = 4'd4;
    frame("f6", 15, 1'b0);

    // Frame 7 shows 04/down; reset lands in the DRIVE phase of slot 2.
    tens("f7_tens", 4);
    slot("f7_ones", 4'b1011, digit(4), 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < BC) chk_disp("f7_dir2", 4'b1111, Dark);
      else        chk_disp("f7_dir2", 4'b1101, Down);
      chk_fs("f7_dir2", 1'b0);
    end
    rst = 1'b1;
    tick();
    chk_disp("midrst", 4'b1111, Dark);
    chk_fs("midrst", 1'b0);
    tick();
    chk_disp("midrst_hold", 4'b1111, Dark);
    rst = 1'b0;

    frame("restart", 0, 1'b1);
    frame("post", 4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
